dkong_scandoubler: RTL and testbench
====================================

// Module: dkong_scandoubler
// PURPOSE
// - Downstream consumer of the video pipeline. Takes the 256-pixel, 15 kHz
//   palettised RGB stream (r3/g3/b2) from the palette stage.
// - Emits each input line twice at double line rate, with its own hsync/vsync
//   and data-enable, for a 31 kHz monitor/encoder.
// - Uses two ping-pong line buffers:
//   - one is written with the current input line;
//   - the other is read twice as the previous line.
// PARAMETERS
// - H_ACTIVE      256  active pixels stored/emitted per line
// - OUT_PIX_CLKS  5    clk cycles per output pixel
// - OUT_LINE_PIX  384  output pixels per output line (OUT_PIX_CLKS*OUT_LINE_PIX = half input line)
// - HS_START      288  output pixel index where hsync goes low
// - HS_LEN        46   hsync low width, in output pixels
// - VS_START      2    output lines after in_vblank rise before vsync goes low
// - VS_LINES      4    vsync low width, in output lines
// PORTS
// - clk            in   1  system clock (same clock as the video pipeline)
// - rst            in   1  synchronous active-high reset
// - in_pix_ce      in   1  input pixel strobe, one clk wide
// - in_valid       in   1  input pixel is active video (qualifies in_pix_ce)
// - in_line_start  in   1  one-clk pulse at start of each input line
// - in_vblank      in   1  input vertical blank level
// - in_r/in_g/in_b in   3/3/2  input colour
// - out_pix_ce     out  1  output pixel strobe, one clk wide
// - out_de         out  1  output data enable
// - out_hsync      out  1  active-low horizontal sync
// - out_vsync      out  1  active-low vertical sync
// - out_r/out_g/out_b out 3/3/2  output colour, zero when out_de=0
// - line_ovf       out  1  sticky: input line carried more than H_ACTIVE pixels
// BEHAVIOUR
// - Reset (sync, rst=1 sampled at posedge clk):
//   - out_r/g/b=0, out_de=0, out_pix_ce=0, out_hsync=1, out_vsync=1, line_ovf=0.
//   - All counters=0; wbank=0; both bank-valid flags=0.
// - Write side:
//   - in_line_start: wbank toggles; waddr<=0; valid flag of the newly written bank cleared.
//   - On in_pix_ce&in_valid with waddr<H_ACTIVE: write {r,g,b} at [wbank][waddr]; waddr++; set bank valid.
//   - On in_pix_ce&in_valid with waddr==H_ACTIVE: write dropped; line_ovf<=1 (sticky until rst).
//   - Same-cycle line_start + pixel: pixel goes to addr 0 of the NEW bank; waddr becomes 1.
// - Read timing generator:
//   - pdiv counts 0..OUT_PIX_CLKS-1. Internal strobe when pdiv==0.
//   - ohcnt increments on each internal strobe, wrapping at OUT_LINE_PIX.
//   - ohalf: 0 = first repeat, 1 = second repeat. On ohcnt wrap, ohalf<=1.
//   - If ohalf is already 1 at a wrap (no new line start), stay at 1 and repeat again.
//   - in_line_start forces pdiv=0, ohcnt=0, ohalf=0; it has priority over the wrap.
//   - Read bank = ~wbank (the line completed before the current one).
// - Output pipeline, fixed latency 2 clk from internal strobe:
//   - clk t: RAM read issued.
//   - clk t+2: out_pix_ce=1 and out_r/g/b/de/hsync/vsync update, then hold until the next update.
// - Enables:
//   - out_de = (ohcnt<H_ACTIVE) & read-bank valid & ~vblank_l.
//   - vblank_l is in_vblank sampled at in_line_start.
// - out_hsync = 0 iff HS_START <= ohcnt < HS_START+HS_LEN.
// - Vertical sync:
//   - vline counter clears on an in_vblank rising edge and increments at every output line start.
//   - It saturates at VS_START+VS_LINES.
//   - out_vsync = 0 iff VS_START <= vline < VS_START+VS_LINES.
// - Reset mid-operation: immediate return to the reset state. The first output line after
//   reset is blank (de=0) because the bank-valid flags are cleared.
// - Line buffers: 2 x H_ACTIVE x 8 bit, inferred block RAM. Write and read never target
//   the same bank, so there is no read-during-write hazard.
// TESTING
// - Reset: hold rst 3 clk
//   -> hsync=1, vsync=1, de=0, rgb=0, line_ovf=0, no out_pix_ce.
// - Ramp line: write pixels 0..255 (value=addr, 10 clk spacing), then pulse line_start
//   -> two output lines each show de for 256 strobes with values 0..255;
//   -> strobes are 5 clk apart; the first strobe is 2 clk after line_start.
// - Overflow: feed 300 valid pixels in one line
//   -> only values 0..255 emitted; line_ovf=1 and stays 1 after the next line_start.
// - Hsync: steady lines
//   -> out_hsync low for exactly 46 strobes (ohcnt 288..333), twice per input line;
//   -> de=0 at ohcnt>=256.
// - Vsync: raise in_vblank
//   -> out_vsync low for output lines 2..5 after the rise, then high;
//   -> de=0 for lines starting while vblank is latched.
// - Mid-line reset after 100 pixels, then 2 full lines
//   -> first doubled pair blank, second pair carries line-1 data; no stale pixels.

Source files
------------

// File: rtl/dkong_scandoubler.sv
// Line-doubling scan converter for the Donkey Kong video pipeline.
// Each 15 kHz input line is captured into one half of a ping-pong line
// buffer while the other half is played back twice at 31 kHz, with
// freshly generated hsync/vsync and data enable.
module dkong_scandoubler #(
    parameter int H_ACTIVE     = 256,
    parameter int OUT_PIX_CLKS = 5,
    parameter int OUT_LINE_PIX = 384,
    parameter int HS_START     = 288,
    parameter int HS_LEN       = 46,
    parameter int VS_START     = 2,
    parameter int VS_LINES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_pix_ce,
    input  logic       in_valid,
    input  logic       in_line_start,
    input  logic       in_vblank,
    input  logic [2:0] in_r,
    input  logic [2:0] in_g,
    input  logic [1:0] in_b,
    output logic       out_pix_ce,
    output logic       out_de,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic [2:0] out_r,
    output logic [2:0] out_g,
    output logic [1:0] out_b,
    output logic       line_ovf
);

    localparam int AW     = $clog2(H_ACTIVE);
    localparam int WAW    = AW + 1;
    localparam int PDW    = $clog2(OUT_PIX_CLKS);
    localparam int HCW    = $clog2(OUT_LINE_PIX);
    localparam int VS_END = VS_START + VS_LINES;
    localparam int VW     = $clog2(VS_END + 1);

    localparam logic [WAW-1:0] WADDR_FULL = WAW'(H_ACTIVE);
    localparam logic [PDW-1:0] PDIV_LAST  = PDW'(OUT_PIX_CLKS - 1);
    localparam logic [HCW-1:0] HCNT_LAST  = HCW'(OUT_LINE_PIX - 1);
    localparam logic [HCW-1:0] HDE_END    = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HS_BEG     = HCW'(HS_START);
    localparam logic [HCW-1:0] HS_FIN     = HCW'(HS_START + HS_LEN);
    localparam logic [VW-1:0]  VL_BEG     = VW'(VS_START);
    localparam logic [VW-1:0]  VL_FIN     = VW'(VS_END);

    // Write side state
    logic           wbank_q, wbank_d;
    logic [WAW-1:0] waddr_q, waddr_d;
    logic [1:0]     bvalid_q, bvalid_d;
    logic           ovf_q, ovf_d;
    logic           wr_en;
    logic [AW:0]    wr_addr;
    logic [7:0]     wr_data;

    // Read timing state
    logic [PDW-1:0] pdiv_q, pdiv_d;
    logic [HCW-1:0] ohcnt_q, ohcnt_d;
    logic           ohalf_q, ohalf_d;
    logic [VW-1:0]  vline_q, vline_d;
    logic           vbl_q, vbl_d;
    logic           vbprev_q;

    logic           rbank;
    logic           strobe;
    logic [HCW-1:0] pix_idx;
    logic [PDW-1:0] pdiv_base;
    logic           line_begin;
    logic [VW-1:0]  vline_eff;
    logic           de_n, hs_n, vs_n;
    logic [AW:0]    rd_addr;

    // Pipeline and output registers
    logic           s1_stb_q, s1_de_q, s1_hs_q, s1_vs_q;
    logic [7:0]     rd_q;
    logic [7:0]     lbuf_q [0:2*H_ACTIVE-1];
    logic           opce_q, ode_q, ohs_q, ovs_q;
    logic [7:0]     orgb_q;

    // Write side: a line start flips to the other bank before any same-cycle pixel lands
    always_comb begin
        wbank_d  = wbank_q;
        waddr_d  = waddr_q;
        bvalid_d = bvalid_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        wr_data  = {in_r, in_g, in_b};
        if (in_line_start) begin
            wbank_d           = ~wbank_q;
            waddr_d           = '0;
            bvalid_d[wbank_d] = 1'b0;
        end
        wr_addr = {wbank_d, waddr_d[AW-1:0]};
        if (in_pix_ce && in_valid) begin
            if (waddr_d < WADDR_FULL) begin
                wr_en             = 1'b1;
                waddr_d           = waddr_d + 1'b1;
                bvalid_d[wbank_d] = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Read timing: a line start acts as an immediate strobe for output pixel 0
    always_comb begin
        rbank     = ~wbank_d;
        strobe    = in_line_start || (pdiv_q == '0);
        pix_idx   = in_line_start ? '0 : ohcnt_q;
        pdiv_base = in_line_start ? '0 : pdiv_q;
        pdiv_d    = (pdiv_base == PDIV_LAST) ? '0 : pdiv_base + 1'b1;
        ohcnt_d   = pix_idx;
        ohalf_d   = in_line_start ? 1'b0 : ohalf_q;
        if (strobe) begin
            if (pix_idx == HCNT_LAST) begin
                ohcnt_d = '0;
                ohalf_d = 1'b1;
            end else begin
                ohcnt_d = pix_idx + 1'b1;
            end
        end
        line_begin = strobe && (pix_idx == '0);
        vline_eff  = (line_begin && (vline_q != VL_FIN)) ? vline_q + 1'b1 : vline_q;
        vline_d    = (in_vblank && !vbprev_q) ? '0 : vline_eff;
        vbl_d      = in_line_start ? in_vblank : vbl_q;
        de_n       = (pix_idx < HDE_END) && bvalid_q[rbank] && !vbl_d;
        hs_n       = !((pix_idx >= HS_BEG) && (pix_idx < HS_FIN));
        vs_n       = !((vline_eff >= VL_BEG) && (vline_eff < VL_FIN));
        rd_addr    = {rbank, pix_idx[AW-1:0]};
    end

    // Line buffer: one write port on the fill bank, one registered read on the playback bank
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lbuf_q[wr_addr] <= wr_data;
        end
        rd_q <= lbuf_q[rd_addr];
    end

    // Control state plus the two-stage output pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q  <= 1'b0;
            waddr_q  <= '0;
            bvalid_q <= '0;
            ovf_q    <= 1'b0;
            pdiv_q   <= '0;
            ohcnt_q  <= '0;
            ohalf_q  <= 1'b0;
            vline_q  <= '0;
            vbl_q    <= 1'b0;
            vbprev_q <= 1'b0;
            s1_stb_q <= 1'b0;
            s1_de_q  <= 1'b0;
            s1_hs_q  <= 1'b1;
            s1_vs_q  <= 1'b1;
            opce_q   <= 1'b0;
            ode_q    <= 1'b0;
            ohs_q    <= 1'b1;
            ovs_q    <= 1'b1;
            orgb_q   <= '0;
        end else begin
            wbank_q  <= wbank_d;
            waddr_q  <= waddr_d;
            bvalid_q <= bvalid_d;
            ovf_q    <= ovf_d;
            pdiv_q   <= pdiv_d;
            ohcnt_q  <= ohcnt_d;
            ohalf_q  <= ohalf_d;
            vline_q  <= vline_d;
            vbl_q    <= vbl_d;
            vbprev_q <= in_vblank;
            s1_stb_q <= strobe;
            s1_de_q  <= de_n;
            s1_hs_q  <= hs_n;
            s1_vs_q  <= vs_n;
            opce_q   <= s1_stb_q;
            if (s1_stb_q) begin
                ode_q  <= s1_de_q;
                ohs_q  <= s1_hs_q;
                ovs_q  <= s1_vs_q;
                orgb_q <= s1_de_q ? rd_q : 8'h00;
            end
        end
    end

    assign out_pix_ce = opce_q;
    assign out_de     = ode_q;
    assign out_hsync  = ohs_q;
    assign out_vsync  = ovs_q;
    assign out_r      = orgb_q[7:5];
    assign out_g      = orgb_q[4:2];
    assign out_b      = orgb_q[1:0];
    assign line_ovf   = ovf_q;

endmodule

// File: tb/tb_dkong_scandoubler.sv
// Self-checking bench for dkong_scandoubler: drives whole input lines,
// captures every output pixel strobe and compares against a line model.
module tb_dkong_scandoubler;

    localparam int LINE_CLKS   = 3840;
    localparam int OUT_STROBES = 768;
    localparam int HALF_PIX    = 384;
    localparam int CAP_MAX     = 800;

    typedef struct {
        int npix;
        int seed;
        int vbToggleAt;
        bit expOvf;
    } lineVec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_pix_ce = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_line_start = 1'b0;
    logic       in_vblank = 1'b0;
    logic [2:0] in_r = '0;
    logic [2:0] in_g = '0;
    logic [1:0] in_b = '0;
    logic       out_pix_ce, out_de, out_hsync, out_vsync, line_ovf;
    logic [2:0] out_r, out_g;
    logic [1:0] out_b;

    int checks = 0;
    int errors = 0;

    int       cyc = 0;
    int       lsCyc = 0;
    bit       lsSeen = 1'b0;
    int       capN = 0;
    int       capCyc [CAP_MAX];
    bit       capDe  [CAP_MAX];
    bit       capHs  [CAP_MAX];
    bit       capVs  [CAP_MAX];
    logic [7:0] capRgb [CAP_MAX];

    logic [7:0] pendData [256];
    logic [7:0] dispData [256];
    bit pendValid = 1'b0;
    bit dispValid = 1'b0;
    bit dispVbl = 1'b0;
    bit pendingRise = 1'b0;
    bit vsKnown = 1'b0;
    int vlineM = 0;
    int vs1 = 0;
    int vs2 = 0;

    lineVec_t vecs [8];

    dkong_scandoubler dut (
        .clk           (clk),
        .rst           (rst),
        .in_pix_ce     (in_pix_ce),
        .in_valid      (in_valid),
        .in_line_start (in_line_start),
        .in_vblank     (in_vblank),
        .in_r          (in_r),
        .in_g          (in_g),
        .in_b          (in_b),
        .out_pix_ce    (out_pix_ce),
        .out_de        (out_de),
        .out_hsync     (out_hsync),
        .out_vsync     (out_vsync),
        .out_r         (out_r),
        .out_g         (out_g),
        .out_b         (out_b),
        .line_ovf      (line_ovf)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to timestamp output strobes
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output strobe belonging to the current input line
    always @(negedge clk) begin
        if (in_line_start) begin
            capN   = 0;
            lsCyc  = cyc;
            lsSeen = 1'b1;
        end else if (out_pix_ce && lsSeen && (cyc >= lsCyc + 2) && (capN < CAP_MAX)) begin
            capCyc[capN] = cyc;
            capDe[capN]  = out_de;
            capHs[capN]  = out_hsync;
            capVs[capN]  = out_vsync;
            capRgb[capN] = {out_r, out_g, out_b};
            capN++;
        end
    end

    function automatic logic [7:0] pixVal(input int seed, input int i);
        if (seed < 0) return 8'(i);
        return 8'(i * 37 + seed * 11);
    endfunction

    function automatic int satLine(input int v);
        return (v >= 6) ? 6 : v + 1;
    endfunction

    function automatic int vsOf(input int v);
        return (v >= 2 && v < 6) ? 0 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        in_pix_ce     = 1'b0;
        in_valid      = 1'b0;
        in_line_start = 1'b0;
        in_r = '0;
        in_g = '0;
        in_b = '0;
    endtask

    // Hold reset for three clocks, checking the idle output state each clock
    task automatic applyReset();
        logic [7:0] rgb;
        clearInputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            rgb = {out_r, out_g, out_b};
            checkOutput("rstHsync", int'(out_hsync), 1);
            checkOutput("rstVsync", int'(out_vsync), 1);
            checkOutput("rstDe", int'(out_de), 0);
            checkOutput("rstRgb", int'(rgb), 0);
            checkOutput("rstOvf", int'(line_ovf), 0);
            checkOutput("rstPixCe", int'(out_pix_ce), 0);
        end
        rst = 1'b0;
        pendValid   = 1'b0;
        vsKnown     = 1'b0;
        pendingRise = 1'b0;
    endtask

    // Drive one input pixel this cycle (valid or a rejected unqualified strobe)
    task automatic drivePixel(input bit valid, input logic [7:0] v);
        in_pix_ce = 1'b1;
        in_valid  = valid;
        in_r = v[7:5];
        in_g = v[4:2];
        in_b = v[1:0];
    endtask

    // One full input line: line start with a same-cycle first pixel, pixels every 10 clk
    task automatic applyStimulus(input int npix, input int seed, input int vbToggleAt);
        for (int i = 0; i < 256; i++) dispData[i] = pendData[i];
        dispValid = pendValid;
        dispVbl   = in_vblank;
        if (pendingRise) begin
            vlineM      = 0;
            vsKnown     = 1'b1;
            pendingRise = 1'b0;
        end
        vs1    = satLine(vlineM);
        vs2    = satLine(vs1);
        vlineM = vs2;
        for (int i = 0; i < 256; i++) pendData[i] = pixVal(seed, i);
        pendValid = (npix > 0);
        for (int c = 0; c < LINE_CLKS; c++) begin
            clearInputs();
            in_line_start = (c == 0);
            if ((c % 10 == 0) && (c / 10 < npix)) drivePixel(1'b1, pixVal(seed, c / 10));
            else if (c % 10 == 5) drivePixel(1'b0, 8'hA5);
            if (c == vbToggleAt) begin
                in_vblank = ~in_vblank;
                if (in_vblank) pendingRise = 1'b1;
            end
            tick();
        end
        clearInputs();
    endtask

    // Compare the strobes captured during the line just driven against the model
    task automatic checkLine();
        int n;
        int idx;
        bit expDe;
        logic [7:0] expRgb;
        checkOutput("strobeCount", capN, OUT_STROBES);
        n = (capN < OUT_STROBES) ? capN : OUT_STROBES;
        for (int k = 0; k < n; k++) begin
            idx    = k % HALF_PIX;
            expDe  = dispValid && !dispVbl && (idx < 256);
            expRgb = expDe ? dispData[idx] : 8'h00;
            checkOutput($sformatf("strobeTime[%0d]", k), capCyc[k] - lsCyc, 2 + 5 * k);
            checkOutput($sformatf("de[%0d]", k), int'(capDe[k]), int'(expDe));
            checkOutput($sformatf("rgb[%0d]", k), int'(capRgb[k]), int'(expRgb));
            checkOutput($sformatf("hsync[%0d]", k), int'(capHs[k]),
                        (idx >= 288 && idx < 334) ? 0 : 1);
            if (vsKnown) begin
                checkOutput($sformatf("vsync[%0d]", k), int'(capVs[k]),
                            vsOf((k < HALF_PIX) ? vs1 : vs2));
            end
        end
    endtask

    initial begin
        vecs[0] = '{npix: 256, seed: 17, vbToggleAt: -1,   expOvf: 1'b0};
        vecs[1] = '{npix: 300, seed: 40, vbToggleAt: -1,   expOvf: 1'b1};
        vecs[2] = '{npix: 256, seed: 99, vbToggleAt: -1,   expOvf: 1'b1};
        vecs[3] = '{npix: 256, seed: 5,  vbToggleAt: 3830, expOvf: 1'b1};
        vecs[4] = '{npix: 256, seed: 6,  vbToggleAt: -1,   expOvf: 1'b1};
        vecs[5] = '{npix: 256, seed: 7,  vbToggleAt: -1,   expOvf: 1'b1};
        vecs[6] = '{npix: 256, seed: 8,  vbToggleAt: 100,  expOvf: 1'b1};
        vecs[7] = '{npix: 256, seed: 9,  vbToggleAt: -1,   expOvf: 1'b1};

        applyReset();

        // Ramp line written straight after reset, no line start needed
        for (int c = 0; c < 2560; c++) begin
            clearInputs();
            if (c % 10 == 0) drivePixel(1'b1, pixVal(-1, c / 10));
            tick();
        end
        clearInputs();
        for (int i = 0; i < 256; i++) pendData[i] = pixVal(-1, i);
        pendValid = 1'b1;

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].npix, vecs[v].seed, vecs[v].vbToggleAt);
            checkLine();
            checkOutput($sformatf("lineOvf[%0d]", v), int'(line_ovf), int'(vecs[v].expOvf));
        end

        // Partial line of 100 pixels interrupted by reset
        for (int c = 0; c < 1000; c++) begin
            clearInputs();
            in_line_start = (c == 0);
            if (c % 10 == 0) drivePixel(1'b1, pixVal(77, c / 10));
            tick();
        end
        applyReset();

        applyStimulus(256, 50, -1);
        checkLine();
        checkOutput("ovfAfterReset0", int'(line_ovf), 0);
        applyStimulus(256, 60, -1);
        checkLine();
        checkOutput("ovfAfterReset1", int'(line_ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
